bcd2binary_216: RTL and testbench
=================================

Name: bcd2binary_216

Overview:
Converts a 6-digit BCD value (unit..h_tho, 0–999999) into a 20-bit binary integer using reverse double dabble: shift right, then subtract 3 from every BCD nibble that is ≥8.
- Multi-cycle engine with a start/busy/done handshake. One iteration per clock, 20 iterations.
- Used on the TaxiFares keypad/config path to turn digit-entered fare rates and distances into binary operands for the fare arithmetic.
- Inverse of the binary-to-BCD display converter.

Parameters:
- BIN_W, 20: output width and iteration count. Fixed at 20 for 6 digits, since 999999 < 2^20.
- CNT_W, 5: iteration counter width. Must satisfy 2^CNT_W > BIN_W.

Ports:
- sys_clk, input, 1: system clock, rising edge.
- sys_rst_n, input, 1: asynchronous active-low reset.
- start, input, 1: conversion request. Sampled only in IDLE.
- unit, input, 4: BCD digit 10^0.
- ten, input, 4: BCD digit 10^1.
- hun, input, 4: BCD digit 10^2.
- tho, input, 4: BCD digit 10^3.
- t_tho, input, 4: BCD digit 10^4.
- h_tho, input, 4: BCD digit 10^5.
- busy, output, 1: high while a conversion is in progress (state ≠ IDLE).
- done, output, 1: one-cycle pulse when out_data and err are updated.
- err, output, 1: high when the last accepted request had any digit >9. Held until the next done.
- out_data, output, 20: binary result. Held until the next done.

Behaviour:
- Reset is sys_rst_n, asynchronous, active-low; clock is sys_clk. Reset values:
  - state = IDLE, cnt = 0, data = 44'd0.
  - busy = 0, done = 0, err = 0, out_data = 0.
- Working register data[43:0] = {BCD[23:0], BIN[19:0]}.
  - data[23:20] holds unit; data[43:40] holds h_tho.
- State IDLE:
  - On start = 1 at edge k0: data <= {h_tho, t_tho, tho, hun, ten, unit, 20'd0}; cnt <= 0; err_q <= (any digit > 9); go to SHIFT.
  - The digits are captured at k0. Input changes after k0 have no effect.
- State SHIFT, one iteration per edge:
  - t = data >> 1 (logical).
  - For each nibble t[23:20], t[27:24], …, t[43:40]: if the nibble is ≥8, subtract 3 (4-bit, no borrow out); otherwise leave it unchanged.
  - data <= t; cnt <= cnt + 1.
  - When cnt == BIN_W−1 (19), go to DONE. SHIFT therefore occupies edges k0+1 to k0+20.
- State DONE, at edge k0+21:
  - out_data <= err_q ? 20'd0 : data[19:0].
  - err <= err_q; done <= 1; go to IDLE.
- done is registered, high for exactly one cycle after edge k0+21, and cleared on the following edge.
- Latency is 21 clocks from the start-sampling edge to done. It is identical for valid and invalid input.
- busy is decoded from the state register. It is high from after k0 through edge k0+21 and low in the cycle in which done is high.
- start while busy (SHIFT or DONE) is ignored, with no queueing. start held high continuously restarts a conversion on every IDLE cycle, i.e. one conversion every 22 clocks.
- After the last iteration the BCD field is all-zero for valid input. This is not checked in RTL; it is a bench assertion.
- Reset asserted mid-conversion aborts immediately: every register returns to its reset value and no done is produced.
- Arithmetic: 44-bit shift; 4-bit per-nibble subtract. No overflow is possible for valid BCD.
- Invalid digits (>9): the conversion still runs but the result is discarded. out_data = 0, err = 1.

Decomposition:
- Package bcd_conv_pkg holds:
  - constants BIN_W = 20, DIGITS = 6, NIB_W = 4, ITER_LAST = 19;
  - the state encoding (IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2).
- Sub-module bcd_nibble_adj: 4-bit combinational cell, out = (in ≥ 8) ? in − 3 : in. Instantiated 6 times on the shifted word.
- Top level holds the FSM, counter, working register and output registers.

Test Plan:
- Reset, then digits 9,9,9,9,9,9 with a start pulse -> done exactly 21 clocks later, out_data = 20'hF423F (999999), err = 0, busy low in the done cycle.
- Digits 1,2,3,4,5,6 (h_tho..unit) -> out_data = 20'h1E240 (123456). Also all-zero digits -> out_data = 0, err = 0, done still pulses after 21 clocks.
- ten = 4'hA, all other digits 0 -> err = 1, out_data = 0, done at 21 clocks. A following valid request with digits 000010 -> err = 0, out_data = 10.
- Start pulsed again at cycles 5 and 21 of a running conversion, and inputs changed mid-run -> single done for the first request, result uses the k0 digits, extra starts ignored.
- sys_rst_n asserted at iteration 10 -> outputs and busy go to 0 immediately, no done. A new start after release converts 000042 -> 42.
- start held high for 50 clocks with fixed 000500 -> done pulses at 22-clock spacing, each with out_data = 500.

Source files
------------

// File: rtl/bcd_conv_pkg.sv
// Shared constants and state encoding for the BCD-to-binary converter.
// Six BCD digits fit in 20 bits because 999999 < 2^20.
package bcd_conv_pkg;

    localparam int unsigned BIN_W     = 20;
    localparam int unsigned DIGITS    = 6;
    localparam int unsigned NIB_W     = 4;
    localparam int unsigned ITER_LAST = BIN_W - 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } conv_state_e;

    function automatic logic digit_invalid(input logic [NIB_W-1:0] d);
        return d > 4'd9;
    endfunction

endpackage

// File: rtl/bcd_nibble_adj.sv
// Reverse double-dabble correction cell: a nibble that became >= 8 after the
// right shift has absorbed a 10/2 carry and is pulled back by 3.
module bcd_nibble_adj (
    input  logic [3:0] din,
    output logic [3:0] dout
);

    assign dout = (din >= 4'd8) ? (din - 4'd3) : din;

endmodule

// File: rtl/bcd2binary_216.sv
// Six-digit BCD to 20-bit binary converter, one reverse double-dabble
// iteration per clock behind a start/busy/done handshake.
module bcd2binary_216 #(
    parameter int unsigned BIN_W = 20,
    parameter int unsigned CNT_W = 5
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             start,
    input  logic [3:0]       unit,
    input  logic [3:0]       ten,
    input  logic [3:0]       hun,
    input  logic [3:0]       tho,
    input  logic [3:0]       t_tho,
    input  logic [3:0]       h_tho,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [BIN_W-1:0] out_data
);

    import bcd_conv_pkg::*;

    localparam int unsigned BCD_W  = DIGITS * NIB_W;
    localparam int unsigned DATA_W = BCD_W + BIN_W;

    conv_state_e       state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W-1:0] data_q;
    logic              err_q;

    logic [DATA_W-1:0] shifted;
    logic [BCD_W-1:0]  adj_bcd;
    logic [DATA_W-1:0] data_nxt;
    logic              in_err;

    assign shifted = data_q >> 1;

    for (genvar i = 0; i < DIGITS; i++) begin : g_adj
        bcd_nibble_adj u_adj (
            .din  (shifted[BIN_W + i*NIB_W +: NIB_W]),
            .dout (adj_bcd[i*NIB_W +: NIB_W])
        );
    end

    assign data_nxt = {adj_bcd, shifted[BIN_W-1:0]};

    assign in_err = digit_invalid(unit)  | digit_invalid(ten)   | digit_invalid(hun) |
                    digit_invalid(tho)   | digit_invalid(t_tho) | digit_invalid(h_tho);

    assign busy = (state_q != IDLE);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            data_q   <= '0;
            err_q    <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            out_data <= '0;
        end else begin
            done <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        data_q  <= {h_tho, t_tho, tho, hun, ten, unit, {BIN_W{1'b0}}};
                        cnt_q   <= '0;
                        err_q   <= in_err;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    data_q <= data_nxt;
                    cnt_q  <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(BIN_W - 1)) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    // Invalid digits still run the full sequence so latency is fixed.
                    out_data <= err_q ? '0 : data_q[BIN_W-1:0];
                    err      <= err_q;
                    done     <= 1'b1;
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd2binary_216.sv
// Directed bench for bcd2binary_216: expected results are queued when a start
// is driven and matched against each done pulse.
module tb_bcd2binary_216;

    logic        sys_clk;
    logic        sys_rst_n;
    logic        start;
    logic [3:0]  unit, ten, hun, tho, t_tho, h_tho;
    logic        busy, done, err;
    logic [19:0] out_data;

    typedef struct {
        logic [19:0] data;
        logic        err;
        int unsigned cyc;
    } exp_t;

    exp_t        sb[$];
    int unsigned cyc;
    int          checks;
    int          failures;

    bcd2binary_216 dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .start     (start),
        .unit      (unit),
        .ten       (ten),
        .hun       (hun),
        .tho       (tho),
        .t_tho     (t_tho),
        .h_tho     (h_tho),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .out_data  (out_data)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    initial cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard consumer: every done must match the oldest queued request.
    always @(negedge sys_clk) begin
        if (sys_rst_n === 1'b1 && done === 1'b1) begin
            chk("done_has_expect", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("out_data", 32'(out_data), 32'(e.data));
                chk("err", 32'(err), 32'(e.err));
                chk("done_cycle", cyc, e.cyc);
                chk("busy_in_done", 32'(busy), 32'd0);
            end
        end
    end

    task automatic set_digits(input logic [3:0] h, input logic [3:0] tt, input logic [3:0] th,
                              input logic [3:0] hu, input logic [3:0] te, input logic [3:0] u);
        h_tho = h; t_tho = tt; tho = th; hun = hu; ten = te; unit = u;
    endtask

    task automatic push_exp(input logic [19:0] d, input logic e, input int unsigned c);
        exp_t x;
        x.data = d; x.err = e; x.cyc = c;
        sb.push_back(x);
    endtask

    // One-cycle start pulse; the sampling edge is the next posedge, done follows 21 later.
    task automatic send(input logic [3:0] h, input logic [3:0] tt, input logic [3:0] th,
                        input logic [3:0] hu, input logic [3:0] te, input logic [3:0] u,
                        input logic [19:0] exp_d, input logic exp_e, input bit do_push);
        @(negedge sys_clk);
        set_digits(h, tt, th, hu, te, u);
        start = 1'b1;
        if (do_push) push_exp(exp_d, exp_e, cyc + 22);
        @(negedge sys_clk);
        start = 1'b0;
        chk("busy_after_start", 32'(busy), 32'd1);
    endtask

    task automatic drain(input string tag, input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge sys_clk);
            n++;
        end
        repeat (2) @(negedge sys_clk);
        chk(tag, sb.size(), 0);
    endtask

    initial begin
        int unsigned base;
        checks    = 0;
        failures  = 0;
        sys_rst_n = 1'b0;
        start     = 1'b0;
        set_digits(4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0);
        repeat (3) @(negedge sys_clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_out", 32'(out_data), 32'd0);
        sys_rst_n = 1'b1;
        repeat (2) @(negedge sys_clk);

        send(4'd9, 4'd9, 4'd9, 4'd9, 4'd9, 4'd9, 20'hF423F, 1'b0, 1'b1);
        drain("drain_999999", 40);
        send(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 20'h1E240, 1'b0, 1'b1);
        drain("drain_123456", 40);
        send(4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 20'd0, 1'b0, 1'b1);
        drain("drain_zero", 40);
        send(4'd0, 4'd0, 4'd0, 4'd0, 4'hA, 4'd0, 20'd0, 1'b1, 1'b1);
        drain("drain_invalid", 40);
        send(4'd0, 4'd0, 4'd0, 4'd0, 4'd1, 4'd0, 20'd10, 1'b0, 1'b1);
        drain("drain_ten", 40);

        // Extra starts in SHIFT and DONE plus digit changes must not disturb the result.
        send(4'd0, 4'd0, 4'd0, 4'd7, 4'd7, 4'd7, 20'd777, 1'b0, 1'b1);
        repeat (3) @(negedge sys_clk);
        set_digits(4'd9, 4'd9, 4'd9, 4'd9, 4'd9, 4'd9);
        start = 1'b1;
        @(negedge sys_clk);
        start = 1'b0;
        repeat (16) @(negedge sys_clk);
        start = 1'b1;
        @(negedge sys_clk);
        start = 1'b0;
        drain("drain_ignore", 40);
        repeat (30) @(negedge sys_clk);

        // Reset mid-conversion: outputs clear at once and no done appears.
        send(4'd0, 4'd0, 4'd0, 4'd0, 4'd5, 4'd5, 20'd0, 1'b0, 1'b0);
        repeat (9) @(negedge sys_clk);
        sys_rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_out", 32'(out_data), 32'd0);
        chk("abort_err", 32'(err), 32'd0);
        repeat (2) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        repeat (30) @(negedge sys_clk);
        chk("abort_no_done_out", 32'(out_data), 32'd0);
        send(4'd0, 4'd0, 4'd0, 4'd0, 4'd4, 4'd2, 20'd42, 1'b0, 1'b1);
        drain("drain_42", 40);

        // Held start: acceptances at the first edge and every 22 clocks after.
        @(negedge sys_clk);
        set_digits(4'd0, 4'd0, 4'd0, 4'd5, 4'd0, 4'd0);
        start = 1'b1;
        base = cyc;
        push_exp(20'd500, 1'b0, base + 22);
        push_exp(20'd500, 1'b0, base + 44);
        push_exp(20'd500, 1'b0, base + 66);
        repeat (50) @(negedge sys_clk);
        start = 1'b0;
        drain("drain_held", 60);
        repeat (30) @(negedge sys_clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

endmodule
